// File: rtl/prod_acc_pkg.sv
// rtl/prod_acc_pkg.sv - shared defaults, count-width helper and FSM state type for prod_accumulator
package prod_acc_pkg;

    localparam int PROD_W_DFLT  = 8;
    localparam int ACC_W_DFLT   = 12;
    localparam int MAX_LEN_DFLT = 32;

    // One extra bit so a count equal to MAX_LEN is representable.
    function automatic int cnt_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    localparam int CNT_W_DFLT = cnt_w(MAX_LEN_DFLT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/prod_accumulator_if.sv
// rtl/prod_accumulator_if.sv - product stream in, frame result out
interface prod_accumulator_if
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DFLT,
    parameter int ACC_W  = ACC_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - unsigned saturating add of a product onto the accumulator
module sat_add
    import prod_acc_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DFLT,
    parameter int PROD_W = PROD_W_DFLT
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        carry = full[ACC_W];
        sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end
endmodule

// File: rtl/prod_accumulator.sv
// rtl/prod_accumulator.sv - frames a product stream into a saturated sum, count and overflow flag
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DFLT,
    parameter int ACC_W   = ACC_W_DFLT,
    parameter int MAX_LEN = MAX_LEN_DFLT
) (
    input logic             clk,
    input logic             rst_n,
    prod_accumulator_if.slave bus
);
    localparam int CNT_W = cnt_w(MAX_LEN);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic               close;

    // The first beat of a frame adds onto zero, so IDLE and ACC share one adder path.
    sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .a     (add_a),
        .b     (bus.in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        accept  = bus.in_valid && in_ready_q;
        add_a   = (state_q == IDLE) ? '0 : acc_q;
        cnt_inc = ((state_q == IDLE) ? '0 : cnt_q) + CNT_W'(1);
        close   = bus.in_last || (cnt_inc == CNT_W'(MAX_LEN));

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ((state_q == ACC) && ovf_q) || add_carry;
                    if (close) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_sum_d   = add_sum;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_d;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    out_sum_d   = '0;
                    out_count_d = '0;
                    out_ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered decode of the next state keeps in_ready independent of in_valid.
        in_ready_d = (state_d != HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// tb/tb_prod_accumulator.sv - directed table and sequence checks for prod_accumulator
module tb_prod_accumulator;

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] prod;
        logic [11:0]     exp_sum;
        logic [5:0]      exp_cnt;
        logic            exp_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    prod_accumulator_if #(.PROD_W(8), .ACC_W(12), .CNT_W(6)) bus ();

    prod_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int v, input int s, input int c, input int o);
        chk({name, "_valid"}, int'(bus.out_valid), v);
        chk({name, "_sum"},   int'(bus.out_sum), s);
        chk({name, "_count"}, int'(bus.out_count), c);
        chk({name, "_ovf"},   int'(bus.out_ovf), o);
    endtask

    // Presents one beat (called just after a falling edge) and returns at the falling edge after acceptance.
    task automatic beat(input logic [7:0] p, input logic last);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1 within 20 cycles");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic handoff(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_out({name, "_after"}, 0, 0, 0, 0);
        chk({name, "_in_ready"}, int'(bus.in_ready), 1);
    endtask

    vec_t vecs[6];

    initial begin
        tests = 0;
        fails = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{3'd4, {8'd45, 8'd36, 8'd84, 8'd22},   12'd187,  6'd4, 1'b0};
        vecs[1] = '{3'd3, {8'd0, 8'd3, 8'd2, 8'd1},       12'd6,    6'd3, 1'b0};
        vecs[2] = '{3'd1, {8'd0, 8'd0, 8'd0, 8'd0},       12'd0,    6'd1, 1'b0};
        vecs[3] = '{3'd2, {8'd0, 8'd0, 8'd255, 8'd255},   12'd510,  6'd2, 1'b0};
        vecs[4] = '{3'd4, {8'd255, 8'd255, 8'd255, 8'd255}, 12'd1020, 6'd4, 1'b0};
        vecs[5] = '{3'd2, {8'd0, 8'd0, 8'd13, 8'd200},    12'd213,  6'd2, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset", 0, 0, 0, 0);
        chk("reset_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < int'(vecs[v].n); b++) begin
                beat(vecs[v].prod[b], (b == int'(vecs[v].n) - 1));
                if (b != int'(vecs[v].n) - 1)
                    chk($sformatf("vec%0d_open", v), int'(bus.out_valid), 0);
            end
            check_out($sformatf("vec%0d", v), 1, int'(vecs[v].exp_sum),
                      int'(vecs[v].exp_cnt), int'(vecs[v].exp_ovf));
            handoff($sformatf("vec%0d_ho", v));
        end

        // Held result, with a competing beat that must wait for the IDLE cycle.
        beat(8'd225, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_prod  = 8'd9;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_out($sformatf("hold%0d", i), 1, 225, 1, 0);
            chk($sformatf("hold%0d_in_ready", i), int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hold_release_valid", int'(bus.out_valid), 0);
        chk("hold_release_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_out("after_hold", 1, 9, 1, 0);
        handoff("after_hold_ho");

        // Cap closes the frame with saturation.
        for (int i = 1; i <= 32; i++) begin
            beat(8'd255, 1'b0);
            if (i == 31) chk("cap_open31", int'(bus.out_valid), 0);
        end
        check_out("cap_sat", 1, 4095, 32, 1);
        handoff("cap_sat_ho");

        // Cap and in_last on the same beat give a single close.
        for (int i = 1; i <= 32; i++) beat(8'd1, (i == 32));
        check_out("cap_last", 1, 32, 32, 0);
        handoff("cap_last_ho");
        @(negedge clk);
        chk("cap_last_single", int'(bus.out_valid), 0);

        // Gap inside a frame.
        beat(8'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("gap%0d_valid", i), int'(bus.out_valid), 0);
            chk($sformatf("gap%0d_ready", i), int'(bus.in_ready), 1);
        end
        beat(8'd20, 1'b1);
        check_out("gap", 1, 30, 2, 0);
        handoff("gap_ho");

        // Reset mid-frame discards the partial sum.
        beat(8'd100, 1'b0);
        beat(8'd50, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_out("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_in_ready", int'(bus.in_ready), 1);
        beat(8'd7, 1'b1);
        check_out("rst_next", 1, 7, 1, 0);

        // Reset in HOLD drops the pending result.
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_out("rst_hold", 0, 0, 0, 0);
        chk("rst_hold_in_ready", int'(bus.in_ready), 1);

        // Back-to-back frames across a handoff.
        beat(8'd3, 1'b0);
        beat(8'd4, 1'b1);
        check_out("b2b_a", 1, 7, 2, 0);
        bus.out_ready = 1'b1;
        beat(8'd11, 1'b0);
        bus.out_ready = 1'b0;
        chk("b2b_b_open", int'(bus.out_valid), 0);
        beat(8'd12, 1'b1);
        check_out("b2b_b", 1, 23, 2, 0);
        handoff("b2b_b_ho");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time got 200000 expected less");
        $fatal(1);
    end

endmodule
